sfifo_flex: RTL

SFIFO_FLEX -- requirements
Module: sfifo_flex

---
 rtl/sfifo_flex.sv | 112 +++++++++++
 1 files changed

// File: rtl/sfifo_flex.sv
// Synchronous FIFO with a registered output stage. DEPTH may be any integer >= 2.
// Occupancy and watermark flags come straight from registers.
module sfifo_flex #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         receiver_valid,
    input  logic [WIDTH-1:0]             receiver_data,
    output logic                         receiver_ready,
    output logic                         sender_valid,
    output logic [WIDTH-1:0]             sender_data,
    input  logic                         sender_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    mem_count;

    logic             do_write;
    logic             do_load;
    logic             do_pop;
    logic [LW-1:0]    count_next;
    logic             valid_next;
    logic [LW-1:0]    level_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    assign receiver_ready = !reset && !flush && (level < DEPTH_L);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        do_write   = receiver_valid && receiver_ready;
        do_pop     = sender_valid && sender_ready && !flush;
        do_load    = !flush && (!sender_valid || sender_ready) && (mem_count != '0);
        count_next = mem_count;
        valid_next = sender_valid;

        if (flush) begin
            count_next = '0;
            valid_next = 1'b0;
        end else begin
            case ({do_write, do_load})
                2'b10:   count_next = mem_count + 1'b1;
                2'b01:   count_next = mem_count - 1'b1;
                default: count_next = mem_count;
            endcase
            if (do_load) begin
                valid_next = 1'b1;
            end else if (do_pop) begin
                valid_next = 1'b0;
            end
        end

        level_next = count_next + LW'(valid_next);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            mem_count    <= '0;
            sender_valid <= 1'b0;
            level        <= '0;
            almost_full  <= (AF_L == '0);
            almost_empty <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_write) wr_ptr <= ptr_inc(wr_ptr);
                if (do_load)  rd_ptr <= ptr_inc(rd_ptr);
            end
            mem_count    <= count_next;
            sender_valid <= valid_next;
            level        <= level_next;
            almost_full  <= (level_next >= AF_L);
            almost_empty <= (level_next <= AE_L);
        end
    end

    // NOTE: storage and the output data word carry no reset; sender_valid qualifies them.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr] <= receiver_data;
        end
        if (do_load && !reset) begin
            sender_data <= mem[rd_ptr];
        end
    end

endmodule
